// File: rtl/tt_pkg.sv
// tt_pkg: shared state encoding, default truth-table mask and depth helper for the scanner
package tt_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} tt_state_e;
  localparam logic [15:0] TT_XOR_MASK = 16'h3C3C;
  function automatic int tt_depth(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: loadable down-counter that reports when the settle time has elapsed
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);
  localparam int W = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(SETTLE);
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps all input vectors of a combinational block, captures and checks its truth table
module truth_table_scanner
  import tt_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 1,
  parameter logic [(1 << N_IN)-1:0] EXPECTED = TT_XOR_MASK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        vec,
  input  logic                   s_in,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1 << N_IN)-1:0] table_out,
  output logic [N_IN:0]          mismatch_cnt,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail
);
  tt_state_e state;
  logic accept, last, miss, zero;
  assign accept = (state == S_IDLE || state == S_DONE) && start;
  assign last = &vec;
  // case inequality so an X from the block under test is reported as a mismatch
  assign miss = s_in !== EXPECTED[vec];
  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept || (state == S_SAMPLE && !last)),
    .dec(state == S_SETTLE),
    .zero(zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      vec <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      table_out <= '0;
      mismatch_cnt <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            vec <= '0;
            table_out <= '0;
            mismatch_cnt <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass <= 1'b0;
            busy <= 1'b1;
            state <= S_SETTLE;
          end else state <= S_IDLE;
        S_SETTLE: state <= zero ? S_SAMPLE : S_SETTLE;
        S_SAMPLE: begin
          table_out[vec] <= s_in;
          if (miss) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!fail_valid) begin
              first_fail <= vec;
              fail_valid <= 1'b1;
            end
          end
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= mismatch_cnt == '0 && !miss;
            state <= S_DONE;
          end else begin
            vec <= vec + 1'b1;
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
